// File: rtl/packet_fifo_core_if.sv
// Stream bundle for packet_fifo_core: write stream, read stream, packet control and fill level.
// The FIFO takes the slave modport; the producer/consumer side takes master.
interface packet_fifo_core_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ABITS = $clog2(DEPTH);

    logic [ABITS-1:0] level_o;
    logic             drop_i;
    logic             save_i;
    logic             redo_i;
    logic             next_i;
    logic             valid_i;
    logic             ready_o;
    logic             last_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic             ready_i;
    logic             last_o;
    logic [WIDTH-1:0] data_o;

    modport slave (
        output level_o, ready_o, valid_o, last_o, data_o,
        input  drop_i, save_i, redo_i, next_i, valid_i, last_i, data_i, ready_i
    );

    modport master (
        input  level_o, ready_o, valid_o, last_o, data_o,
        output drop_i, save_i, redo_i, next_i, valid_i, last_i, data_i, ready_i
    );
endinterface

// File: rtl/packet_fifo_core.sv
// Single-clock packet FIFO: words become readable only once their packet commits.
// Define PACKET_FIFO_REDO_EN to enable read-side packet replay (redo_i) and skip (next_i).
module packet_fifo_core #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int OUTREG     = 1,
    parameter int USE_LENGTH = 0,
    parameter int MAX_LENGTH = 64
) (
    input  logic               clock,
    input  logic               reset,
    packet_fifo_core_if.slave  bus
);
    localparam int ABITS = $clog2(DEPTH);
    localparam int PB    = ABITS + 1;

    typedef logic [PB-1:0] ptr_t;

    localparam ptr_t LEN_LAST = ptr_t'(MAX_LENGTH - 1);

    logic [WIDTH:0] mem [DEPTH];

    ptr_t wr_ptr, wr_cmt, rd_ptr, rd_pkt;
    ptr_t wr_len, lvl;
    ptr_t rd_ptr_nx, rd_pkt_nx;
    logic full, wr_xfer, wr_last, rd_xfer, rd_jump;

    // Write side
    assign full        = (wr_ptr - rd_pkt) == ptr_t'(DEPTH);
    assign bus.ready_o = !full && !reset;
    assign wr_xfer     = bus.valid_i && bus.ready_o;
    assign wr_len      = wr_ptr - wr_cmt;
    assign wr_last     = bus.last_i || (USE_LENGTH != 0 && wr_len == LEN_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            wr_cmt <= '0;
        end else if (bus.drop_i) begin
            wr_ptr <= wr_cmt;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(wr_xfer);
            if (wr_xfer && wr_last)
                wr_cmt <= wr_ptr + ptr_t'(1);
            else if (bus.save_i)
                wr_cmt <= wr_ptr + ptr_t'(wr_xfer);
        end
    end

    // A write dropped in the same cycle lands in free space and is never exposed.
    always_ff @(posedge clock) begin
        if (wr_xfer)
            mem[wr_ptr[ABITS-1:0]] <= {wr_last, bus.data_i};
    end

    assign lvl         = wr_cmt - rd_ptr;
    assign bus.level_o = lvl[ABITS] ? '1 : lvl[ABITS-1:0];

    assign rd_xfer = bus.valid_o && bus.ready_i;

`ifdef PACKET_FIFO_REDO_EN
    logic [DEPTH-1:0] lastv;
    ptr_t             avail, nxt_pkt, idx;
    logic             found;

    // Last flags kept in flops so next_i can scan ahead without touching the RAM.
    always_ff @(posedge clock) begin
        if (reset)
            lastv <= '0;
        else if (wr_xfer)
            lastv[wr_ptr[ABITS-1:0]] <= wr_last;
    end

    always_comb begin
        avail   = wr_cmt - rd_ptr;
        nxt_pkt = wr_cmt;
        idx     = rd_ptr;
        found   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + ptr_t'(k);
            if (!found && ptr_t'(k) < avail && lastv[idx[ABITS-1:0]]) begin
                found   = 1'b1;
                nxt_pkt = idx + ptr_t'(1);
            end
        end
    end

    always_comb begin
        rd_ptr_nx = rd_ptr + ptr_t'(rd_xfer);
        rd_pkt_nx = rd_pkt;
        rd_jump   = 1'b0;
        if (rd_xfer && bus.last_o)
            rd_pkt_nx = rd_ptr + ptr_t'(1);
        if (bus.redo_i) begin
            rd_ptr_nx = rd_pkt;
            rd_pkt_nx = rd_pkt;
            rd_jump   = 1'b1;
        end else if (bus.next_i) begin
            rd_ptr_nx = nxt_pkt;
            rd_pkt_nx = nxt_pkt;
            rd_jump   = 1'b1;
        end
    end
`else
    logic unused_ctl;
    assign unused_ctl = bus.redo_i | bus.next_i;

    // No replay possible, so space is released word by word.
    always_comb begin
        rd_ptr_nx = rd_ptr + ptr_t'(rd_xfer);
        rd_pkt_nx = rd_ptr_nx;
        rd_jump   = 1'b0;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            rd_pkt <= '0;
        end else begin
            rd_ptr <= rd_ptr_nx;
            rd_pkt <= rd_pkt_nx;
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            // fe_ptr runs one word ahead of rd_ptr whenever the output register is full.
            ptr_t           fe_ptr;
            logic           out_vld, load;
            logic [WIDTH:0] out_word;

            assign load = (fe_ptr != wr_cmt) && (!out_vld || bus.ready_i) && !rd_jump;

            always_ff @(posedge clock) begin
                if (reset) begin
                    fe_ptr  <= '0;
                    out_vld <= 1'b0;
                end else if (rd_jump) begin
                    fe_ptr  <= rd_ptr_nx;
                    out_vld <= 1'b0;
                end else if (load) begin
                    fe_ptr  <= fe_ptr + ptr_t'(1);
                    out_vld <= 1'b1;
                end else if (rd_xfer) begin
                    out_vld <= 1'b0;
                end
            end

            always_ff @(posedge clock) begin
                if (load)
                    out_word <= mem[fe_ptr[ABITS-1:0]];
            end

            assign bus.valid_o = out_vld;
            assign bus.last_o  = out_vld && out_word[WIDTH];
            assign bus.data_o  = out_vld ? out_word[WIDTH-1:0] : '0;
        end else begin : g_comb
            logic           rd_vld;
            logic [WIDTH:0] rd_word;

            assign rd_vld      = rd_ptr != wr_cmt;
            assign rd_word     = mem[rd_ptr[ABITS-1:0]];
            assign bus.valid_o = rd_vld;
            assign bus.last_o  = rd_vld && rd_word[WIDTH];
            assign bus.data_o  = rd_vld ? rd_word[WIDTH-1:0] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_packet_fifo_core.sv
// Directed bench: DUT a (DEPTH 64, comb read, 4-word length limit), DUT b (DEPTH 16, registered read).
module tb_packet_fifo_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    packet_fifo_core_if #(.WIDTH(8), .DEPTH(64)) ifa ();
    packet_fifo_core_if #(.WIDTH(8), .DEPTH(16)) ifb ();

    packet_fifo_core #(.WIDTH(8), .DEPTH(64), .OUTREG(0), .USE_LENGTH(1), .MAX_LENGTH(4))
        dut_a (.clock(clk), .reset(rst), .bus(ifa));
    packet_fifo_core #(.WIDTH(8), .DEPTH(16), .OUTREG(1), .USE_LENGTH(0), .MAX_LENGTH(16))
        dut_b (.clock(clk), .reset(rst), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [8:0] exp_q[$];
    bit         wr_done;

    initial begin
        {ifa.drop_i, ifa.save_i, ifa.redo_i, ifa.next_i, ifa.valid_i, ifa.last_i, ifa.ready_i} = '0;
        {ifb.drop_i, ifb.save_i, ifb.redo_i, ifb.next_i, ifb.valid_i, ifb.last_i, ifb.ready_i} = '0;
        ifa.data_i = '0;
        ifb.data_i = '0;
        @(negedge clk);
        tick;
        chk("rst_ready_a", 32'(ifa.ready_o), 0);
        chk("rst_valid_a", 32'(ifa.valid_o), 0);
        chk("rst_last_a",  32'(ifa.last_o), 0);
        chk("rst_data_a",  32'(ifa.data_o), 0);
        chk("rst_level_a", 32'(ifa.level_o), 0);
        chk("rst_valid_b", 32'(ifb.valid_o), 0);
        chk("rst_data_b",  32'(ifb.data_o), 0);
        rst = 1'b0;
        tick;
        chk("ready_after_rst", 32'(ifa.ready_o), 1);

        // 1: one 4-word packet, invisible until its last word lands
        for (int i = 0; i < 4; i++) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = 8'(16 + i);
            ifa.last_i  = (i == 3);
            chk("t1_vld_pre", 32'(ifa.valid_o), 0);
            tick;
        end
        ifa.valid_i = 1'b0;
        ifa.last_i  = 1'b0;
        chk("t1_vld",   32'(ifa.valid_o), 1);
        chk("t1_level", 32'(ifa.level_o), 4);
        ifa.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", 32'(ifa.data_o), 32'(16 + i));
            chk("t1_last", 32'(ifa.last_o), 32'(i == 3));
            tick;
        end
        ifa.ready_i = 1'b0;
        chk("t1_vld_end", 32'(ifa.valid_o), 0);
        chk("t1_lvl_end", 32'(ifa.level_o), 0);

        // 2: six words without last; length limit commits the first four
        for (int i = 0; i < 6; i++) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = 8'(32 + i);
            tick;
        end
        ifa.valid_i = 1'b0;
        chk("t2_level", 32'(ifa.level_o), 4);
        ifa.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_data", 32'(ifa.data_o), 32'(32 + i));
            chk("t2_last", 32'(ifa.last_o), 32'(i == 3));
            tick;
        end
        ifa.ready_i = 1'b0;
        chk("t2_hidden", 32'(ifa.valid_o), 0);
        ifa.drop_i = 1'b1;
        tick;
        ifa.drop_i = 1'b0;

        // 3: partial packet dropped, then a 2-word packet
        for (int i = 0; i < 3; i++) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = 8'(48 + i);
            tick;
        end
        ifa.valid_i = 1'b0;
        chk("t3_lvl_part", 32'(ifa.level_o), 0);
        ifa.drop_i = 1'b1;
        tick;
        ifa.drop_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = 8'(64 + i);
            ifa.last_i  = (i == 1);
            tick;
        end
        ifa.valid_i = 1'b0;
        ifa.last_i  = 1'b0;
        chk("t3_level", 32'(ifa.level_o), 2);
        ifa.ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("t3_data", 32'(ifa.data_o), 32'(64 + i));
            chk("t3_last", 32'(ifa.last_o), 32'(i == 1));
            tick;
        end
        ifa.ready_i = 1'b0;
        chk("t3_vld_end", 32'(ifa.valid_o), 0);

`ifdef PACKET_FIFO_REDO_EN
        // 4: replay and skip
        for (int i = 0; i < 8; i++) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = (i < 4) ? 8'(80 + i) : 8'(96 + i - 4);
            ifa.last_i  = (i == 3) || (i == 7);
            tick;
        end
        ifa.valid_i = 1'b0;
        ifa.last_i  = 1'b0;
        ifa.ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("t4_data", 32'(ifa.data_o), 32'(80 + i));
            tick;
        end
        ifa.ready_i = 1'b0;
        ifa.redo_i  = 1'b1;
        tick;
        ifa.redo_i = 1'b0;
        chk("t4_redo", 32'(ifa.data_o), 80);
        ifa.next_i = 1'b1;
        tick;
        ifa.next_i = 1'b0;
        chk("t4_next",     32'(ifa.data_o), 96);
        chk("t4_next_lvl", 32'(ifa.level_o), 4);
        ifa.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_pkt2", 32'(ifa.data_o), 32'(96 + i));
            tick;
        end
        ifa.ready_i = 1'b0;
        chk("t4_vld_end", 32'(ifa.valid_o), 0);
`endif

        // 5: fill to 64 words, then release space
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = 8'(i);
            ifa.last_i  = (i % 4 == 3);
            tick;
        end
        ifa.valid_i = 1'b0;
        ifa.last_i  = 1'b0;
        chk("t5_full",  32'(ifa.ready_o), 0);
        chk("t5_level", 32'(ifa.level_o), 63);
        chk("t5_data0", 32'(ifa.data_o), 0);
        ifa.ready_i = 1'b1;
        tick;
        ifa.ready_i = 1'b0;
        chk("t5_lvl_rd1", 32'(ifa.level_o), 63);
`ifdef PACKET_FIFO_REDO_EN
        chk("t5_still_full", 32'(ifa.ready_o), 0);
        ifa.ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("t5_data", 32'(ifa.data_o), 32'(i));
            tick;
        end
        ifa.ready_i = 1'b0;
        chk("t5_free", 32'(ifa.ready_o), 1);
`else
        chk("t5_free", 32'(ifa.ready_o), 1);
`endif

        // 6a: registered read adds one cycle after commit
        ifb.valid_i = 1'b1;
        ifb.data_i  = 8'hA5;
        ifb.last_i  = 1'b1;
        tick;
        ifb.valid_i = 1'b0;
        ifb.last_i  = 1'b0;
        chk("t6_lat0", 32'(ifb.valid_o), 0);
        tick;
        chk("t6_lat1", 32'(ifb.valid_o), 1);
        chk("t6_lat1_word", 32'({ifb.last_o, ifb.data_o}), 32'h1A5);
        ifb.ready_i = 1'b1;
        tick;
        ifb.ready_i = 1'b0;
        chk("t6_lat_empty", 32'(ifb.valid_o), 0);

        // 6b: 20 packets with random consumer throttling
        wr_done = 1'b0;
        fork
            begin : writer
                logic [7:0] wb = 8'h00;
                for (int p = 0; p < 20; p++) begin
                    int len = $urandom_range(1, 5);
                    for (int w = 0; w < len; w++) begin
                        int g = 0;
                        ifb.valid_i = 1'b1;
                        ifb.data_i  = wb;
                        ifb.last_i  = (w == len - 1);
                        while (!ifb.ready_o && g < 2000) begin
                            @(negedge clk);
                            g++;
                        end
                        if (g >= 2000)
                            chk("t6_wr_stall", 32'(ifb.ready_o), 1);
                        exp_q.push_back({ifb.last_i, wb});
                        wb++;
                        @(negedge clk);
                    end
                end
                ifb.valid_i = 1'b0;
                ifb.last_i  = 1'b0;
                wr_done     = 1'b1;
            end
            begin : reader
                int         c    = 0;
                bit         hold = 1'b0;
                logic [8:0] held = '0;
                logic [8:0] e;
                while (!(wr_done && exp_q.size() == 0) && c < 5000) begin
                    if (hold)
                        chk("t6_hold", 32'({ifb.last_o, ifb.data_o}), 32'(held));
                    ifb.ready_i = ($urandom_range(0, 3) != 0);
                    if (ifb.valid_o && ifb.ready_i) begin
                        if (exp_q.size() == 0) begin
                            chk("t6_extra", 32'(ifb.data_o), 32'h1FF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("t6_word", 32'({ifb.last_o, ifb.data_o}), 32'(e));
                        end
                    end
                    hold = ifb.valid_o && !ifb.ready_i;
                    held = {ifb.last_o, ifb.data_o};
                    c++;
                    @(negedge clk);
                end
                ifb.ready_i = 1'b0;
            end
        join
        chk("t6_left",    32'(exp_q.size()), 0);
        chk("t6_vld_end", 32'(ifb.valid_o), 0);
        chk("t6_lvl_end", 32'(ifb.level_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
